jk_mod_counter: RTL and testbench

Synchronous modulo-N up/down counter whose state register is a bank of JK flip-flop cells. Each bit's J/K excitation is derived from the current and next count values. It is the stage directly downstream of the single JK flip-flop cell: it consumes that cell's behaviour, replicated WIDTH times with shared clock and reset. The count, its complement, a terminal-count flag and a registered wrap pulse drive divider and sequencing logic further downstream.

---
 rtl/jk_mod_counter.sv | 75 +++++++
 tb/tb_jk_mod_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK flip-flop cells.
// Each cell's J/K excitation comes from the current count and the selected next count.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Range checks use one extra bit so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] n;
    logic             din_ok;
    logic             at_last;
    logic             at_zero;

    function automatic logic [WIDTH-1:0] jk_step(
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k,
        input logic [WIDTH-1:0] cur
    );
        return (j & ~cur) | (~k & cur);
    endfunction

    assign din_ok  = {1'b0, din} < MOD_V;
    assign at_last = (state == LAST);
    assign at_zero = (state == '0);

    always_comb begin
        n = state;
        if (load)
            n = din_ok ? din : '0;
        else if (en && up)
            n = at_last ? '0 : state + WIDTH'(1);
        else if (en)
            n = at_zero ? LAST : state - WIDTH'(1);
    end

    // Set/clear excitation only: a toggle shows up as J or K depending on the current bit.
    assign j_vec = ~state & n;
    assign k_vec = state & ~n;

    assign tc = en & ~load & ((up & at_last) | (~up & at_zero));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= jk_step(j_vec, k_vec, state);
            wrap     <= tc;
            load_err <= load & ~din_ok;
        end
    end

    assign q  = state;
    assign qb = ~state;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10) with a small reference model
// for the randomized excitation run.
`timescale 1ns/1ps
module tb_jk_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       tc;
    logic       wrap;
    logic       load_err;

    int n_cmp = 0;
    int n_bad = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
        .q(q), .qb(qb), .j_vec(j_vec), .k_vec(k_vec), .tc(tc),
        .wrap(wrap), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        @(negedge clk);
        load = 1'b1; din = v; en = 1'b0;
        tick();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
        #12;
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL reset_q got %h want 0", q); end
        n_cmp++; if (qb !== 4'hF) begin n_bad++; $display("FAIL reset_qb got %h want f", qb); end
        n_cmp++; if (wrap !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got wrap=%b load_err=%b want 0/0", wrap, load_err); end
        n_cmp++; if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin n_bad++; $display("FAIL reset_comb got j=%h k=%h tc=%b want 0/0/0", j_vec, k_vec, tc); end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q = 4'(i % 10);
            n_cmp++; if (q !== exp_q) begin n_bad++; $display("FAIL up_q step %0d got %0d want %0d", i, q, exp_q); end
            n_cmp++; if (qb !== ~exp_q) begin n_bad++; $display("FAIL up_qb step %0d got %h want %h", i, qb, ~exp_q); end
            n_cmp++; if (tc !== (exp_q == 4'd9)) begin n_bad++; $display("FAIL up_tc step %0d got %b want %b", i, tc, exp_q == 4'd9); end
            n_cmp++; if (wrap !== (exp_q == 4'd0)) begin n_bad++; $display("FAIL up_wrap step %0d got %b want %b", i, wrap, exp_q == 4'd0); end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        do_load(4'd2);
        n_cmp++; if (q !== 4'd2) begin n_bad++; $display("FAIL dn_load got %0d want 2", q); end
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (q !== seq[i]) begin n_bad++; $display("FAIL dn_q step %0d got %0d want %0d", i, q, seq[i]); end
            n_cmp++; if (tc !== (seq[i] == 4'd0)) begin n_bad++; $display("FAIL dn_tc step %0d got %b want %b", i, tc, seq[i] == 4'd0); end
            n_cmp++; if (wrap !== (seq[i] == 4'd9)) begin n_bad++; $display("FAIL dn_wrap step %0d got %b want %b", i, wrap, seq[i] == 4'd9); end
            if (seq[i] == 4'd0) begin
                n_cmp++; if (j_vec !== 4'b1001 || k_vec !== 4'b0000) begin n_bad++; $display("FAIL dn_excite got j=%b k=%b want 1001/0000", j_vec, k_vec); end
            end
        end
        @(negedge clk);
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_load_err();
        @(negedge clk);
        load = 1'b1; din = 4'd12; en = 1'b0;
        tick();
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL lerr_q got %0d want 0", q); end
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL lerr_pulse got %b want 1", load_err); end
        @(negedge clk);
        din = 4'd7;
        tick();
        n_cmp++; if (q !== 4'd7) begin n_bad++; $display("FAIL lerr_reload got %0d want 7", q); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL lerr_clear got %b want 0", load_err); end
        @(negedge clk);
        load = 1'b0;
        tick();
        n_cmp++; if (q !== 4'd7 || load_err !== 1'b0) begin n_bad++; $display("FAIL lerr_hold got q=%0d load_err=%b want 7/0", q, load_err); end
    endtask

    task automatic test_priority();
        do_load(4'd9);
        en = 1'b1; up = 1'b1;
        #1;
        n_cmp++; if (tc !== 1'b1) begin n_bad++; $display("FAIL pri_tc_pre got %b want 1", tc); end
        load = 1'b1; din = 4'd3;
        #1;
        n_cmp++; if (tc !== 1'b0) begin n_bad++; $display("FAIL pri_tc got %b want 0", tc); end
        n_cmp++; if (j_vec !== 4'b0010 || k_vec !== 4'b1000) begin n_bad++; $display("FAIL pri_excite got j=%b k=%b want 0010/1000", j_vec, k_vec); end
        tick();
        n_cmp++; if (q !== 4'd3) begin n_bad++; $display("FAIL pri_q got %0d want 3", q); end
        n_cmp++; if (wrap !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL pri_pulses got wrap=%b load_err=%b want 0/0", wrap, load_err); end
        @(negedge clk);
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(4'd5);
        en = 1'b1; up = 1'b1;
        tick();
        n_cmp++; if (q !== 4'd6) begin n_bad++; $display("FAIL ar_pre got %0d want 6", q); end
        #2;
        reset = 1'b1;
        #0.5;
        n_cmp++; if (q !== 4'd0 || qb !== 4'hF) begin n_bad++; $display("FAIL ar_now got q=%0d qb=%h want 0/f", q, qb); end
        n_cmp++; if (wrap !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL ar_pulses got wrap=%b load_err=%b want 0/0", wrap, load_err); end
        #0.5;
        reset = 1'b0;
        #0.5;
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL ar_after got %0d want 0", q); end
        tick();
        n_cmp++; if (q !== 4'd1) begin n_bad++; $display("FAIL ar_resume got %0d want 1", q); end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_hold();
        do_load(4'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (q !== 4'd5) begin n_bad++; $display("FAIL hold_q step %0d got %0d want 5", i, q); end
            n_cmp++; if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin n_bad++; $display("FAIL hold_comb step %0d got j=%h k=%h tc=%b want 0/0/0", i, j_vec, k_vec, tc); end
        end
    endtask

    task automatic test_random();
        logic [3:0] mq, mn, ej, ek;
        logic       etc, ewrap, elerr;
        mq = 4'd5;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            en   = 1'($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 9) == 0);
            din  = 4'($urandom_range(0, 15));
            if (load)            mn = (din < 4'd10) ? din : 4'd0;
            else if (en && up)   mn = (mq == 4'd9) ? 4'd0 : mq + 4'd1;
            else if (en)         mn = (mq == 4'd0) ? 4'd9 : mq - 4'd1;
            else                 mn = mq;
            ej = ~mq & mn;
            ek = mq & ~mn;
            etc = en && !load && ((up && mq == 4'd9) || (!up && mq == 4'd0));
            ewrap = etc;
            elerr = load && (din >= 4'd10);
            #1;
            n_cmp++; if ((j_vec & k_vec) !== 4'd0 || j_vec !== ej || k_vec !== ek) begin n_bad++; $display("FAIL rnd_excite cyc %0d got j=%b k=%b want %b/%b", i, j_vec, k_vec, ej, ek); end
            n_cmp++; if (tc !== etc) begin n_bad++; $display("FAIL rnd_tc cyc %0d got %b want %b", i, tc, etc); end
            tick();
            mq = mn;
            n_cmp++; if (q !== mq) begin n_bad++; $display("FAIL rnd_q cyc %0d got %0d want %0d", i, q, mq); end
            n_cmp++; if (wrap !== ewrap || load_err !== elerr) begin n_bad++; $display("FAIL rnd_pulses cyc %0d got wrap=%b load_err=%b want %b/%b", i, wrap, load_err, ewrap, elerr); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_err();
        test_priority();
        test_async_reset();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
